// File: rtl/strength_bus_arbiter.sv
// strength_bus_arbiter: registered strength-resolving arbiter for one shared bus.
// Optional `conflict` output when STRENGTH_CONFLICT_DETECT_EN is defined.
module strength_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_str,
    input  logic [DW*N_REQ-1:0]  req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     gnt,
    output logic [DW-1:0]        bus_data,
    output logic [2:0]           bus_str,
    output logic                 bus_valid,
    output logic                 busy
`ifdef STRENGTH_CONFLICT_DETECT_EN
    ,
    output logic                 conflict
`endif
);

    localparam int unsigned IW  = $clog2(N_REQ);
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned HCW = 8;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]    bus_data_q, bus_data_d;
    logic [2:0]       bus_str_q, bus_str_d;
    logic             bus_valid_q, bus_valid_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [2:0]       str_a  [N_REQ];
    logic [DW-1:0]    data_a [N_REQ];
    logic [N_REQ-1:0] elig, cand;
    logic [2:0]       max_s;
    logic [IW1-1:0]   scan;
    logic [IW-1:0]    win_idx;
    logic             win_found;
    logic             own_req, own_last, preempt;
    logic [2:0]       own_str;

    // Unpack flat request buses into per-requester slices
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            str_a[i]  = req_str[3*i +: 3];
            data_a[i] = req_data[DW*i +: DW];
        end
    end

    // Strongest eligible wins; ties go to the first candidate at or after rr_ptr
    always_comb begin
        elig      = '0;
        cand      = '0;
        max_s     = '0;
        scan      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req[i] && (str_a[i] != 3'd0);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && (str_a[i] > max_s)) max_s = str_a[i];
        end
        for (int i = 0; i < N_REQ; i++) begin
            cand[i] = elig[i] && (str_a[i] == max_s);
        end
        for (int k = 0; k < N_REQ; k++) begin
            scan = IW1'(rr_ptr_q) + IW1'(k);
            if (scan >= IW1'(N_REQ)) scan = scan - IW1'(N_REQ);
            if (!win_found && cand[scan[IW-1:0]]) begin
                win_idx   = scan[IW-1:0];
                win_found = 1'b1;
            end
        end
    end

    // Current owner's view and strictly-stronger challenger detection
    always_comb begin
        own_req  = req[owner_q];
        own_last = req_last[owner_q];
        own_str  = str_a[owner_q];
        preempt  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && (IW'(i) != owner_q) && (str_a[i] > own_str)) preempt = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        bus_data_d  = bus_data_q;
        bus_str_d   = bus_str_q;
        bus_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus_str_d = 3'd0;
                if (win_found) begin
                    state_d    = OWN;
                    gnt_d      = N_REQ'(1) << win_idx;
                    owner_d    = win_idx;
                    hold_cnt_d = '0;
                end
            end
            OWN: begin
                hold_cnt_d = hold_cnt_q + HCW'(1);
                if (!own_req) begin
                    // Owner dropped out: nothing to capture this beat
                    bus_str_d = 3'd0;
                    state_d   = TURN;
                    gnt_d     = '0;
                end else begin
                    bus_data_d  = data_a[owner_q];
                    bus_str_d   = own_str;
                    bus_valid_d = 1'b1;
                    if (own_last || (hold_cnt_q == HOLD_LAST) || preempt) begin
                        state_d = TURN;
                        gnt_d   = '0;
                    end
                end
                if (state_d == TURN) begin
                    rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
                end
            end
            TURN: begin
                bus_str_d = 3'd0;
                gnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                bus_str_d = 3'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            bus_data_q  <= '0;
            bus_str_q   <= '0;
            bus_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            bus_data_q  <= bus_data_d;
            bus_str_q   <= bus_str_d;
            bus_valid_q <= bus_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign bus_data  = bus_data_q;
    assign bus_str   = bus_str_q;
    assign bus_valid = bus_valid_q;
    assign busy      = busy_q;

`ifdef STRENGTH_CONFLICT_DETECT_EN
    logic          conflict_q, conflict_d;
    logic          tie_diff, have_ref;
    logic [DW-1:0] ref_data;

    // Tied strongest drivers disagreeing on data is what a real net resolves to X
    always_comb begin
        tie_diff = 1'b0;
        have_ref = 1'b0;
        ref_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cand[i]) begin
                if (!have_ref) begin
                    ref_data = data_a[i];
                    have_ref = 1'b1;
                end else if (data_a[i] != ref_data) begin
                    tie_diff = 1'b1;
                end
            end
        end
        conflict_d = (state_q == IDLE) && win_found && tie_diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= 1'b0;
        else        conflict_q <= conflict_d;
    end

    assign conflict = conflict_q;
`endif

endmodule
